// File: rtl/i2s_tx_scheduler.sv
// rtl/i2s_tx_scheduler.sv - I2S transmit frame sequencer: lrclk generation, stereo-pair FIFO, underrun policy
module i2s_tx_scheduler #(
  parameter int SLOT_BITS  = 32,
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          rst,
  input  logic                          sclk,
  input  logic                          en,
  input  logic [DATA_W-1:0]             in_left,
  input  logic [DATA_W-1:0]             in_right,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          mute,
  input  logic                          underrun_mode,
  input  logic                          clr_underrun,
  output logic                          lrclk,
  output logic [DATA_W-1:0]             tx_data,
  output logic                          frame_start,
  output logic                          running,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun_flag,
  output logic [15:0]                   underrun_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [7:0]       LAST_BIT = 8'(SLOT_BITS - 1);

  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_DRAIN} state_t;

  state_t             state;
  logic [7:0]         bit_cnt;
  logic [DATA_W-1:0]  hold_right;
  logic [DATA_W-1:0]  last_left;
  logic [DATA_W-1:0]  last_right;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [DATA_W-1:0]  mem_left  [FIFO_DEPTH];
  logic [DATA_W-1:0]  mem_right [FIFO_DEPTH];

  logic               slot_end;
  logic               start_now;
  logic               stop_now;
  logic               fifo_empty;
  logic               do_push;
  logic               do_pop;
  logic               underrun;
  logic [DATA_W-1:0]  sel_left;
  logic [DATA_W-1:0]  sel_right;

  assign in_ready   = (fifo_level != FULL_LVL);
  assign fifo_empty = (fifo_level == '0);
  assign slot_end   = (bit_cnt == LAST_BIT);
  // A frame starts either straight out of STOP or at the end of a right slot while still enabled.
  assign start_now  = en && ((state == ST_STOP) || (slot_end && lrclk));
  assign stop_now   = !en && (state != ST_STOP) && slot_end && lrclk;
  assign do_push    = in_valid && in_ready;
  assign do_pop     = start_now && !fifo_empty;
  assign underrun   = start_now && fifo_empty;

  // Pick the pair for the next frame: FIFO head, else repeat-last or silence.
  always_comb begin
    sel_left  = '0;
    sel_right = '0;
    if (!fifo_empty) begin
      sel_left  = mem_left[rd_ptr];
      sel_right = mem_right[rd_ptr];
    end else if (underrun_mode) begin
      sel_left  = last_left;
      sel_right = last_right;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge sclk) begin
    if (do_push) begin
      mem_left[wr_ptr]  <= in_left;
      mem_right[wr_ptr] <= in_right;
    end
  end

  // Frame sequencer, FIFO bookkeeping and underrun accounting.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state         <= ST_STOP;
      bit_cnt       <= '0;
      lrclk         <= 1'b1;
      tx_data       <= '0;
      hold_right    <= '0;
      last_left     <= '0;
      last_right    <= '0;
      frame_start   <= 1'b0;
      running       <= 1'b0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      fifo_level    <= '0;
      underrun_flag <= 1'b0;
      underrun_cnt  <= '0;
    end else begin
      frame_start <= 1'b0;
      if (start_now) begin
        state       <= ST_RUN;
        running     <= 1'b1;
        lrclk       <= 1'b0;
        bit_cnt     <= '0;
        frame_start <= 1'b1;
        tx_data     <= mute ? '0 : sel_left;
        hold_right  <= mute ? '0 : sel_right;
        if (do_pop) begin
          last_left  <= mem_left[rd_ptr];
          last_right <= mem_right[rd_ptr];
          rd_ptr     <= rd_ptr + PTR_W'(1);
        end
      end else if (stop_now) begin
        state   <= ST_STOP;
        running <= 1'b0;
        bit_cnt <= '0;
        tx_data <= '0;
      end else if (state != ST_STOP) begin
        state <= en ? ST_RUN : ST_DRAIN;
        if (slot_end) begin
          lrclk   <= 1'b1;
          bit_cnt <= '0;
          tx_data <= hold_right;
        end else begin
          bit_cnt <= bit_cnt + 8'd1;
        end
      end

      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase

      if (clr_underrun) begin
        underrun_flag <= 1'b0;
        underrun_cnt  <= '0;
      end else if (underrun) begin
        underrun_flag <= 1'b1;
        if (underrun_cnt != 16'hFFFF) begin
          underrun_cnt <= underrun_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// tb/tb_i2s_tx_scheduler.sv - randomized self-checking bench for i2s_tx_scheduler
module tb_i2s_tx_scheduler;

  localparam int S  = 32;
  localparam int DW = 24;
  localparam int D  = 4;

  logic          rst;
  logic          sclk;
  logic          en;
  logic [DW-1:0] in_left;
  logic [DW-1:0] in_right;
  logic          in_valid;
  logic          in_ready;
  logic          mute;
  logic          underrun_mode;
  logic          clr_underrun;
  logic          lrclk;
  logic [DW-1:0] tx_data;
  logic          frame_start;
  logic          running;
  logic [2:0]    fifo_level;
  logic          underrun_flag;
  logic [15:0]   underrun_cnt;

  i2s_tx_scheduler #(.SLOT_BITS(S), .DATA_W(DW), .FIFO_DEPTH(D)) dut (
    .rst(rst), .sclk(sclk), .en(en), .in_left(in_left), .in_right(in_right),
    .in_valid(in_valid), .in_ready(in_ready), .mute(mute),
    .underrun_mode(underrun_mode), .clr_underrun(clr_underrun), .lrclk(lrclk),
    .tx_data(tx_data), .frame_start(frame_start), .running(running),
    .fifo_level(fifo_level), .underrun_flag(underrun_flag), .underrun_cnt(underrun_cnt)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: position inside the 2*S-cycle frame plus a queue of pending pairs.
  logic [DW-1:0] q_l[$];
  logic [DW-1:0] q_r[$];
  bit            m_run;
  int            m_pos;
  logic [DW-1:0] m_tx;
  logic [DW-1:0] m_right;
  logic [DW-1:0] m_last_l;
  logic [DW-1:0] m_last_r;
  bit            m_fs;
  int            m_cnt;
  bit            m_flag;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    q_l.delete();
    q_r.delete();
    m_run = 0; m_pos = 0; m_tx = '0; m_right = '0;
    m_last_l = '0; m_last_r = '0; m_fs = 0; m_cnt = 0; m_flag = 0;
  endtask

  task automatic model_step();
    bit start, stop, push, under;
    logic [DW-1:0] pl, pr;
    pl = '0; pr = '0;
    push  = in_valid && (q_l.size() < D);
    start = en && (!m_run || m_pos == 2*S-1);
    stop  = !en && m_run && m_pos == 2*S-1;
    under = 0;
    m_fs  = 0;
    if (start) begin
      if (q_l.size() > 0) begin
        pl = q_l.pop_front();
        pr = q_r.pop_front();
        m_last_l = pl;
        m_last_r = pr;
      end else begin
        under = 1;
        if (underrun_mode) begin
          pl = m_last_l;
          pr = m_last_r;
        end
      end
      m_tx    = mute ? '0 : pl;
      m_right = mute ? '0 : pr;
      m_run = 1; m_pos = 0; m_fs = 1;
    end else if (stop) begin
      m_run = 0; m_pos = 0; m_tx = '0;
    end else if (m_run) begin
      m_pos++;
      if (m_pos == S) m_tx = m_right;
    end
    if (push) begin
      q_l.push_back(in_left);
      q_r.push_back(in_right);
    end
    if (clr_underrun) begin
      m_cnt = 0; m_flag = 0;
    end else if (under) begin
      m_flag = 1;
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic check_all();
    check("lrclk",        32'(lrclk),         32'(m_run ? (m_pos >= S) : 1'b1));
    check("tx_data",      32'(tx_data),       32'(m_tx));
    check("frame_start",  32'(frame_start),   32'(m_fs));
    check("running",      32'(running),       32'(m_run));
    check("fifo_level",   32'(fifo_level),    32'(q_l.size()));
    check("in_ready",     32'(in_ready),      32'(q_l.size() < D));
    check("underrun_flag",32'(underrun_flag), 32'(m_flag));
    check("underrun_cnt", 32'(underrun_cnt),  32'(m_cnt));
  endtask

  // One clock: model consumes the current inputs, DUT sees the edge, outputs compared 1 ns later.
  task automatic cycle();
    model_step();
    @(posedge sclk);
    #1;
    check_all();
  endtask

  task automatic rand_cycles(input int n, input int p_en, input int p_valid,
                             input int p_mute, input int p_clr);
    for (int i = 0; i < n; i++) begin
      en           = ($urandom_range(99) < p_en);
      in_valid     = ($urandom_range(99) < p_valid);
      in_left      = DW'($urandom);
      in_right     = DW'($urandom);
      mute         = ($urandom_range(99) < p_mute);
      clr_underrun = ($urandom_range(99) < p_clr);
      cycle();
    end
  endtask

  task automatic run_until_pos(input int target);
    int k;
    k = 0;
    while (!(m_run && m_pos == target) && k < 300) begin
      cycle();
      k++;
    end
    if (!(m_run && m_pos == target)) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_pos: position %0d not reached, model at %0d", target, m_pos);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; in_left = '0; in_right = '0; in_valid = 1'b0;
    mute = 1'b0; underrun_mode = 1'b0; clr_underrun = 1'b0;
    model_reset();
    @(posedge sclk);
    #1;
    check_all();
    rst = 1'b0;

    // Preload two known pairs while stopped, then start; third frame underruns with zeros.
    in_valid = 1'b1; in_left = 24'hA5A5A5; in_right = 24'h5A5A5A;
    cycle();
    in_left = 24'h123456; in_right = 24'h654321;
    cycle();
    in_valid = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 140; i++) cycle();

    // Repeat-last underrun policy, then clear held high across underrunning frame starts.
    underrun_mode = 1'b1;
    for (int i = 0; i < 70; i++) cycle();
    clr_underrun = 1'b1;
    for (int i = 0; i < 70; i++) cycle();
    clr_underrun = 1'b0;

    // Fill the FIFO to full with pushes still offered, across a frame start.
    rand_cycles(80, 100, 100, 0, 0);

    // Drop en at bit 5 of a left slot; both slots must finish before STOP.
    in_valid = 1'b0;
    run_until_pos(5);
    en = 1'b0;
    for (int i = 0; i < 80; i++) cycle();

    // Mute raised mid-frame applies from the next frame on.
    rand_cycles(20, 100, 100, 0, 0);
    in_valid = 1'b0; en = 1'b1;
    run_until_pos(40);
    mute = 1'b1;
    for (int i = 0; i < 70; i++) cycle();
    mute = 1'b0;

    // Randomized phases with varied traffic, en drops, mute and clears.
    for (int ph = 0; ph < 8; ph++) begin
      underrun_mode = 1'($urandom_range(1));
      rand_cycles(900, 97 + $urandom_range(3), $urandom_range(100), $urandom_range(30), 2);
    end

    // Asynchronous reset at bit 10 of a right slot, then restart with en already high.
    en = 1'b1; in_valid = 1'b0; mute = 1'b0; clr_underrun = 1'b0;
    run_until_pos(S + 10);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge sclk);
    #1;
    check_all();
    rst = 1'b0;
    cycle();
    rand_cycles(300, 99, 40, 10, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_tx_scheduler.md
Name: i2s_tx_scheduler

Overview:
Frame sequencer for the I2S transmit path. It generates lrclk from sclk, buffers stereo sample pairs from an upstream valid/ready source in a small FIFO, and presents the correct 24-bit channel word on tx_data for each half-frame, so the serializer receives stable data aligned to every lrclk edge. It also handles start/stop, mute, and underrun policy, and reports underruns.

Parameters:
SLOT_BITS, 32, sclk cycles per half-frame (channel slot); legal values are 25..255.
DATA_W, 24, sample width; must match the serializer.
FIFO_DEPTH, 4, stereo-pair FIFO entries; must be a power of 2 and at least 2.

Ports:
rst  in  1  asynchronous, active-high reset
sclk  in  1  bit clock; all logic on posedge
en  in  1  run request
in_left  in  DATA_W  left sample of the pushed pair
in_right  in  DATA_W  right sample of the pushed pair
in_valid  in  1  upstream pair valid
in_ready  out  1  FIFO can accept; equals !full
mute  in  1  zero output; sampled at frame start
underrun_mode  in  1  0 = send zeros on underrun; 1 = repeat last popped pair
clr_underrun  in  1  synchronous clear of underrun_cnt and underrun_flag
lrclk  out  1  word select; 0 = left slot, 1 = right slot
tx_data  out  DATA_W  word for the current slot, to the serializer data input
frame_start  out  1  one-cycle pulse on the edge that begins a left slot
running  out  1  high in RUN and DRAIN
fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries
underrun_flag  out  1  sticky; set on any underrun
underrun_cnt  out  16  saturating underrun count

Behaviour:
- Reset values: lrclk=1, tx_data=0, frame_start=0, running=0, in_ready=1, fifo_level=0, underrun_flag=0, underrun_cnt=0. The FIFO is emptied, last-pair registers are zeroed, the state is STOP, and bit_cnt=0. Reset asserted mid-frame aborts immediately. There is no partial-frame recovery.
- FIFO: a push occurs when in_valid and in_ready are both high. A pop occurs only at frame start. A push while full is impossible because in_ready=0. A pop while full and a same-cycle push cannot coincide. A pop while empty counts as an underrun. A push into an empty FIFO on the same edge as frame start is not bypassed: that frame underruns, and the pushed pair is kept for the next frame.
- States:
  - STOP: lrclk held at 1, tx_data=0, bit_cnt=0. If en=1, the next edge is a frame start and the state moves to RUN.
  - RUN: bit_cnt counts 0..SLOT_BITS-1 and wraps.
    - On the edge where bit_cnt==SLOT_BITS-1 and lrclk==0: set lrclk to 1 and load tx_data from hold_right.
    - On the edge where bit_cnt==SLOT_BITS-1 and lrclk==1: if en=1, this is a frame start; if en=0, go to STOP with lrclk staying at 1, so no edge is produced.
  - DRAIN: alias of RUN. running stays high until the current frame's right slot completes. en falling mid-frame never truncates a slot.
- Frame start edge, all updates registered on the same edge:
  - lrclk goes to 0, bit_cnt to 0, frame_start to 1.
  - mute_f is captured from mute.
  - Pair selection: pop a pair if available; otherwise use the last popped pair (underrun_mode=1) or zeros (underrun_mode=0).
  - tx_data is set to the selected left sample, or 0 if mute. hold_right is set to the selected right sample, or 0 if mute.
  - The last-pair registers update only on a real pop.
- tx_data changes only on lrclk-toggle edges and on entry to STOP. It is stable for the full slot.
- Start timing: in the first frame after STOP, lrclk falls from 1 to 0, so the serializer sees an edge.
- Underrun: underrun_flag is set and underrun_cnt increments, saturating at 0xFFFF. clr_underrun wins over a same-cycle increment.
- Mute applies to whole frames only and still consumes the FIFO.

Test Plan:
1. Reset, preload 2 pairs (L=0xA5A5A5/R=0x5A5A5A, L=0x123456/R=0x654321), then en=1 -> lrclk falls 1 cycle later with tx_data=0xA5A5A5. lrclk rises 32 cycles later with tx_data=0x5A5A5A. The second frame starts at cycle 65 with 0x123456. fifo_level steps 2→1→0.
2. FIFO empty at frame start with underrun_mode=0 -> tx_data=0 in both slots, underrun_cnt=1, underrun_flag=1. Repeat with underrun_mode=1 -> the last pair is repeated. Then clr_underrun together with an underrun -> cnt=0.
3. Push 4 pairs with no pops -> in_ready=0 and fifo_level=4. A push attempt is ignored. After the next frame start, in_ready=1.
4. Drop en at bit_cnt=5 of the left slot -> both slots complete, STOP is entered at the end of the right slot, lrclk stays at 1, running=0, tx_data=0, and the FIFO keeps its remaining entries.
5. Assert mute mid-frame -> the current frame is unaffected. The next frame has tx_data=0 in both slots and fifo_level decrements.
6. Assert rst at bit_cnt=10 of the right slot -> outputs immediately take their reset values and fifo_level=0. Release with en=1 -> a clean frame start occurs one cycle later.
